// File: rtl/pc_ras_pkg.sv
// Shared package for the program counter with return-address stack.
// Provides the modePC operation enum and default width constants.
package pico;

    typedef enum logic [2:0] {
        INCREMENT = 3'd0,
        RELATIVE  = 3'd1,
        JUMP      = 3'd2,
        CALL      = 3'd3,
        RETURN    = 3'd4
    } modePC;

    localparam int PICO_AW    = 16;
    localparam int PICO_DW    = 16;
    localparam int PICO_DEPTH = 4;

endpackage

// File: rtl/pc_ras_if.sv
// Control/status bundle of pc_ras.
//   halt_i  : freeze all state
//   mode_i  : operation (modePC)
//   data_i  : signed offset or target
//   addr_o  : current program address
//   depth_o : valid stack entries
//   full_o / empty_o : stack occupancy flags
//   err_o   : sticky stack-fault flag
// master drives the controls, slave is the pc_ras side.
interface pc_ras_if
    import pico::*;
#(
    parameter int AW    = PICO_AW,
    parameter int DW    = PICO_DW,
    parameter int DEPTH = PICO_DEPTH
);
    logic                          halt_i;
    modePC                         mode_i;
    logic signed [DW-1:0]          data_i;
    logic [AW-1:0]                 addr_o;
    logic [$clog2(DEPTH+1)-1:0]    depth_o;
    logic                          full_o;
    logic                          empty_o;
    logic                          err_o;

    modport master (
        output halt_i, mode_i, data_i,
        input  addr_o, depth_o, full_o, empty_o, err_o
    );

    modport slave (
        input  halt_i, mode_i, data_i,
        output addr_o, depth_o, full_o, empty_o, err_o
    );
endinterface

// File: rtl/ras_lifo.sv
// Return-address LIFO. Entry 0 is the top of stack; a push shifts every
// entry down one slot, so a push while full drops the oldest entry and the
// stack behaves circularly. A pop shifts up and clears the vacated slot.
//   clk_i, rst_i : clock, async active-high reset
//   i_push/i_pop : operations (mutually exclusive; pop ignored when empty)
//   i_data       : value to push
//   o_top        : top entry
//   o_count      : valid entries
//   o_full/o_empty : occupancy flags derived from the count register
module ras_lifo #(
    parameter int AW    = 16,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH+1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [AW-1:0] i_data,
    output logic [AW-1:0] o_top,
    output logic [CW-1:0] o_count,
    output logic          o_full,
    output logic          o_empty
);
    logic [DEPTH-1:0][AW-1:0] r_stk;
    logic [CW-1:0]            r_count;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_stk   <= '0;
            r_count <= '0;
        end else if (i_push) begin
            r_stk[0] <= i_data;
            for (int i = 1; i < DEPTH; i++) r_stk[i] <= r_stk[i-1];
            if (!o_full) r_count <= r_count + CW'(1);
        end else if (i_pop && !o_empty) begin
            for (int i = 0; i < DEPTH-1; i++) r_stk[i] <= r_stk[i+1];
            r_stk[DEPTH-1] <= '0;
            r_count        <= r_count - CW'(1);
        end
    end

    assign o_top   = r_stk[0];
    assign o_count = r_count;
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
endmodule

// File: rtl/pc_ras.sv
// Program counter with return-address stack.
//   clk_i : clock, rising edge
//   rst_i : async active-high reset
//   bus   : pc_ras_if.slave (halt_i, mode_i, data_i in; addr_o, depth_o,
//           full_o, empty_o, err_o out)
// Macro PC_RAS_FAULT_TRAP_EN: when defined, CALL-when-full and
// RETURN-when-empty step the address by one and set a sticky err_o. When
// undefined, the stack is circular on overflow, RETURN on empty goes to
// address 0, and err_o is constant 0.
module pc_ras
    import pico::*;
#(
    parameter int AW    = PICO_AW,
    parameter int DW    = PICO_DW,
    parameter int DEPTH = PICO_DEPTH
) (
    input  logic     clk_i,
    input  logic     rst_i,
    pc_ras_if.slave  bus
);
    localparam int CW = $clog2(DEPTH+1);

    logic [AW-1:0] r_addr;
    logic [AW-1:0] w_next, w_inc, w_tgt, w_off, w_top;
    logic          w_push, w_pop, w_full, w_empty;
    logic [CW-1:0] w_count;

    // Target is the low AW bits of data_i; the offset is data_i sign-extended
    // or truncated to AW bits.
    generate
        if (DW >= AW) begin : g_trunc
            assign w_tgt = bus.data_i[AW-1:0];
            assign w_off = bus.data_i[AW-1:0];
            if (DW > AW) begin : g_hi
                logic w_unused_hi;
                assign w_unused_hi = ^bus.data_i[DW-1:AW];
            end
        end else begin : g_ext
            assign w_tgt = {{(AW-DW){1'b0}}, bus.data_i};
            assign w_off = {{(AW-DW){bus.data_i[DW-1]}}, bus.data_i};
        end
    endgenerate

    assign w_inc = r_addr + AW'(1);

`ifdef PC_RAS_FAULT_TRAP_EN
    logic w_fault;
    logic r_err;
`endif

    always_comb begin
        w_next = r_addr;
        w_push = 1'b0;
        w_pop  = 1'b0;
`ifdef PC_RAS_FAULT_TRAP_EN
        w_fault = 1'b0;
`endif
        if (!bus.halt_i) begin
            case (bus.mode_i)
                RELATIVE: w_next = r_addr + w_off;
                JUMP:     w_next = w_tgt;
                CALL: begin
`ifdef PC_RAS_FAULT_TRAP_EN
                    if (w_full) begin
                        w_next  = w_inc;
                        w_fault = 1'b1;
                    end else begin
                        w_push = 1'b1;
                        w_next = w_tgt;
                    end
`else
                    // Overflow drops the oldest entry inside the LIFO.
                    w_push = 1'b1;
                    w_next = w_tgt;
`endif
                end
                RETURN: begin
                    if (!w_empty) begin
                        w_pop  = 1'b1;
                        w_next = w_top;
                    end else begin
`ifdef PC_RAS_FAULT_TRAP_EN
                        w_next  = w_inc;
                        w_fault = 1'b1;
`else
                        w_next  = '0;
`endif
                    end
                end
                default: w_next = w_inc;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_addr <= '0;
        else       r_addr <= w_next;
    end

`ifdef PC_RAS_FAULT_TRAP_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)        r_err <= 1'b0;
        else if (w_fault) r_err <= 1'b1;
    end
    assign bus.err_o = r_err;
`else
    assign bus.err_o = 1'b0;
`endif

    ras_lifo #(.AW(AW), .DEPTH(DEPTH), .CW(CW)) u_lifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_inc),
        .o_top   (w_top),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign bus.addr_o  = r_addr;
    assign bus.depth_o = w_count;
    assign bus.full_o  = w_full;
    assign bus.empty_o = w_empty;
endmodule

// File: tb/tb_pc_ras.sv
module tb_pc_ras;
    import pico::*;

    localparam int AW    = 8;
    localparam int DW    = 16;
    localparam int DEPTH = 4;
`ifdef PC_RAS_FAULT_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef struct {
        int addr;
        int depth;
        bit err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    // Reference model: address as an integer, stack as a queue (front = top).
    int   m_addr;
    int   m_stk[$];
    bit   m_err;
    exp_t scb[$];

    pc_ras_if #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) bus ();

    pc_ras #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_addr = 0;
        m_stk.delete();
        m_err  = 1'b0;
    endtask

    task automatic model_step(input modePC md, input logic [DW-1:0] d, input bit h);
        int nxt;
        if (h) return;
        nxt = (m_addr + 1) % 256;
        case (md)
            INCREMENT: m_addr = nxt;
            RELATIVE:  m_addr = (m_addr + int'($signed(d))) & 8'hFF;
            JUMP:      m_addr = int'(d) & 8'hFF;
            CALL: begin
                if (m_stk.size() < DEPTH || !TRAP) begin
                    m_stk.push_front(nxt);
                    if (m_stk.size() > DEPTH) void'(m_stk.pop_back());
                    m_addr = int'(d) & 8'hFF;
                end else begin
                    m_addr = nxt;
                    m_err  = 1'b1;
                end
            end
            RETURN: begin
                if (m_stk.size() > 0) m_addr = m_stk.pop_front();
                else if (TRAP) begin
                    m_addr = nxt;
                    m_err  = 1'b1;
                end else m_addr = 0;
            end
            default: m_addr = nxt;
        endcase
    endtask

    task automatic step(input modePC md, input logic [DW-1:0] d, input bit h);
        exp_t e;
        @(negedge clk);
        rst        = 1'b0;
        bus.mode_i = md;
        bus.data_i = d;
        bus.halt_i = h;
        model_step(md, d, h);
        e.addr  = m_addr;
        e.depth = m_stk.size();
        e.err   = m_err;
        scb.push_back(e);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_addr"},  int'(bus.addr_o), 0);
        chk({tag, "_depth"}, int'(bus.depth_o), 0);
        chk({tag, "_empty"}, int'(bus.empty_o), 1);
        chk({tag, "_full"},  int'(bus.full_o), 0);
        chk({tag, "_err"},   int'(bus.err_o), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        #1 chk_reset_state("rst");
    endtask

    // Monitor: the DUT presents a new state after every rising edge.
    exp_t mon_e;
    always @(posedge clk) begin
        #1;
        if (scb.size() > 0) begin
            mon_e = scb.pop_front();
            chk("addr",  int'(bus.addr_o),  mon_e.addr);
            chk("depth", int'(bus.depth_o), mon_e.depth);
            chk("full",  int'(bus.full_o),  int'(mon_e.depth == DEPTH));
            chk("empty", int'(bus.empty_o), int'(mon_e.depth == 0));
            chk("err",   int'(bus.err_o),   int'(mon_e.err));
        end
    end

    initial begin
        bus.halt_i = 1'b0;
        bus.mode_i = INCREMENT;
        bus.data_i = '0;
        model_reset();
        #3 chk_reset_state("init");

        // Wrap after 256 increments, then hold under halt.
        for (int i = 0; i < 256; i++) step(INCREMENT, 16'h0, 1'b0);
        for (int i = 0; i < 3; i++)   step(INCREMENT, 16'h0, 1'b1);

        // Relative with a negative offset and a truncated jump target.
        step(JUMP, 16'h0010, 1'b0);
        step(RELATIVE, 16'hFFFD, 1'b0);
        step(JUMP, 16'h01A5, 1'b0);
        step(RELATIVE, 16'h0070, 1'b0);

        // Nested call/return.
        step(JUMP, 16'h0020, 1'b0);
        step(CALL, 16'h0040, 1'b0);
        step(CALL, 16'h0060, 1'b0);
        step(RETURN, 16'h0, 1'b0);
        step(RETURN, 16'h0, 1'b0);

        // Overflow: five calls, then four returns.
        do_reset();
        for (int i = 0; i < 5; i++) step(CALL, 16'(16'h0080 + 16 * i), 1'b0);
        step(RETURN, 16'h0, 1'b1);
        for (int i = 0; i < 4; i++) step(RETURN, 16'h0, 1'b0);

        // Return on empty.
        do_reset();
        step(JUMP, 16'h0033, 1'b0);
        step(RETURN, 16'h0, 1'b0);

        // Randomized traffic with occasional halts and resets.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) do_reset();
            step(modePC'($urandom_range(0, 4)), 16'($urandom), $urandom_range(0, 9) == 0);
        end

        // Reset between edges after two calls, then resume with a CALL.
        do_reset();
        step(CALL, 16'h0044, 1'b0);
        step(CALL, 16'h0055, 1'b0);
        @(posedge clk);
        #3 rst = 1'b1;
        model_reset();
        #1;
        chk("midrst_addr",  int'(bus.addr_o), 0);
        chk("midrst_depth", int'(bus.depth_o), 0);
        chk("midrst_empty", int'(bus.empty_o), 1);
        step(CALL, 16'h0066, 1'b0);
        step(RETURN, 16'h0, 1'b0);

        for (int i = 0; i < 10 && scb.size() > 0; i++) @(posedge clk);
        #2;
        if (scb.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expected responses left, required 0", scb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pc_ras.md
PC_RAS -- requirements
Module: pc_ras

Interface
REQ-001 The block SHALL have parameter AW, default 16: program address width in bits.
REQ-002 The block SHALL have parameter DW, default 16: signed operand width in bits.
REQ-003 The block SHALL have parameter DEPTH, default 4: return-address stack entries, minimum 2.
REQ-004 The block SHALL have port clk_i, input, 1 bit: the single clock, rising edge active.
REQ-005 The block SHALL have port rst_i, input, 1 bit: asynchronous active-high reset.
REQ-006 The block SHALL have port halt_i, input, 1 bit: freezes all state when high.
REQ-007 The block SHALL have port mode_i, input, modePC: INCREMENT, RELATIVE, JUMP, CALL or RETURN.
REQ-008 The block SHALL have port data_i, input, DW bits signed: offset or target.
REQ-009 The block SHALL have port addr_o, output, AW bits: current program address.
REQ-010 The block SHALL have port depth_o, output, $clog2(DEPTH+1) bits: count of valid stack entries.
REQ-011 The block SHALL have port full_o, output, 1 bit: high when depth_o equals DEPTH.
REQ-012 The block SHALL have port empty_o, output, 1 bit: high when depth_o equals 0.
REQ-013 The block SHALL have port err_o, output, 1 bit: sticky stack-fault flag.

Function
REQ-014 The block SHALL update addr_o and the stack on the rising edge after mode_i and data_i are sampled, with one-cycle latency and no combinational path from inputs to outputs.
REQ-015 When halt_i=1, the block SHALL hold addr_o, the stack, depth_o and err_o regardless of mode_i.
REQ-016 In INCREMENT mode, the block SHALL set addr_o to addr_o+1 modulo 2^AW, so all-ones wraps to 0.
REQ-017 In RELATIVE mode, the block SHALL set addr_o to addr_o plus data_i sign-extended or truncated to AW bits, modulo 2^AW.
REQ-018 In JUMP mode, the block SHALL set addr_o to data_i[AW-1:0] and leave the stack unchanged.
REQ-019 In CALL mode with the stack not full, the block SHALL push addr_o+1 (modulo 2^AW), set addr_o to data_i[AW-1:0] and increment depth_o.
REQ-020 In RETURN mode with the stack not empty, the block SHALL set addr_o to the top entry, clear that entry to 0 and decrement depth_o.
REQ-021 The block SHALL keep full_o and empty_o registered-consistent with depth_o in every cycle.
REQ-022 Stack faults (CALL when full, RETURN when empty) SHALL be handled as defined in the Configuration section.

Reset
REQ-023 While rst_i=1, the block SHALL immediately force addr_o=0, all stack entries=0, depth_o=0, empty_o=1, full_o=0 and err_o=0, independent of clk_i.
REQ-024 A reset asserted mid-CALL or mid-RETURN SHALL discard the operation, and the first edge after deassertion SHALL execute the mode then presented.

Configuration
REQ-025 The feature SHALL be controlled by macro PC_RAS_FAULT_TRAP_EN.
REQ-026 With PC_RAS_FAULT_TRAP_EN defined, CALL when full SHALL leave the stack untouched, set addr_o to addr_o+1 and set err_o.
REQ-027 With PC_RAS_FAULT_TRAP_EN defined, RETURN when empty SHALL set addr_o to addr_o+1 and set err_o.
REQ-028 With PC_RAS_FAULT_TRAP_EN defined, err_o SHALL stay high until reset.
REQ-029 With PC_RAS_FAULT_TRAP_EN undefined, CALL when full SHALL discard the oldest entry, push addr_o+1, jump, and keep depth_o=DEPTH as a circular stack.
REQ-030 With PC_RAS_FAULT_TRAP_EN undefined, RETURN when empty SHALL set addr_o to 0.
REQ-031 With PC_RAS_FAULT_TRAP_EN undefined, err_o SHALL be tied to 0.

Structure
REQ-032 The shared package pico SHALL define modePC as INCREMENT, RELATIVE, JUMP, CALL and RETURN, plus default width constants.
REQ-033 The return-address storage SHALL be the sub-module ras_lifo, with push, pop, top, count, full and empty, parametrised by AW and DEPTH.

Verification
REQ-034 With AW=8 and DEPTH=4, holding INCREMENT from reset for 256 cycles SHALL give addr_o=0x00 after the wrap, and 3 cycles with halt_i=1 SHALL hold the value.
REQ-035 With addr_o=0x10, RELATIVE with data_i=-3 SHALL give 0x0D, and JUMP with data_i=0x1A5 SHALL give 0xA5.
REQ-036 From addr_o=0x20, CALL 0x40, CALL 0x60, RETURN, RETURN SHALL give addr_o=0x40, 0x60, 0x41, 0x21, with depth_o=1, 2, 1, 0.
REQ-037 Five CALLs from empty with DEPTH=4 SHALL, with the macro, set err_o with depth_o=4 and no fifth jump, and without it, lose the first return address so that after four RETURNs depth_o=0 and err_o=0.
REQ-038 RETURN on empty at addr_o=0x33 SHALL give 0x34 with err_o=1 with the macro, and 0x00 with err_o=0 without it.
REQ-039 Asserting rst_i between clock edges after two CALLs SHALL immediately zero addr_o and depth_o and set empty_o=1.
